// File: rtl/wb_burst_master.sv
// wb_burst_master
// Wishbone B3 burst initiator. Takes a command (direction, start address,
// beat count, burst type), then runs an incrementing or wrapping burst
// using registered-feedback cycle type identifiers. It handles slave wait
// states, error and retry terminations, and a no-response timeout.
//
// Ports
//   wb_clk_i, wb_rst_n_i           clock, asynchronous active-low reset
//   cmd_*                          command handshake and fields (adr, len, bte, we)
//   wdat_* / wdat_ready_o          write data stream towards the bus
//   rdat_o, rdat_valid_o           read data stream (no backpressure)
//   done_o, status_o               end-of-command pulse and sticky status
//   wb_*                           Wishbone B3 master signals
//   dbg_state_o                    current FSM state (0 idle, 1 bus, 2 retry wait)
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. cmd: cmd_ready_o is high only in IDLE. wdat: the
// word on wdat_i is consumed in the cycle where wdat_ready_o is high, which is
// exactly the cycle the slave acks a write beat. rdat has no ready; a word is
// presented for one cycle with rdat_valid_o high.
module wb_burst_master #(
    parameter int RETRY_GAP = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [7:0]  cmd_len_i,
    input  logic [1:0]  cmd_bte_i,
    input  logic [31:0] wdat_i,
    input  logic [3:0]  wdat_sel_i,
    input  logic        wdat_valid_i,
    output logic        wdat_ready_o,
    output logic [31:0] rdat_o,
    output logic        rdat_valid_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_RWAIT = 2'd2
    } state_t;

    localparam logic [7:0]  RTY_MAX  = 8'(MAX_RETRY);
    localparam logic [15:0] GAP_LAST = 16'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);
    localparam logic [31:0] TO_LAST  = 32'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit          TO_EN    = (TIMEOUT != 0);

    state_t      state;
    logic        stb_q;
    logic        len_zero_q;   // single classic cycle: cti stays 000
    logic [7:0]  rem_q;        // beats left after the current one
    logic [7:0]  rty_cnt;
    logic [15:0] gap_cnt;
    logic [31:0] to_cnt;

    logic        term_ack, term_err, term_rty;
    logic        fin;
    logic [1:0]  fin_status;
    logic        rd_beat;

    // Address bits [1:0] are forced to zero on the bus.
    logic [1:0]  unused_adr_lsb;
    assign unused_adr_lsb = cmd_adr_i[1:0];

    function automatic logic [2:0] cti_for(input logic len_zero, input logic [7:0] rem);
        if (len_zero)        return 3'b000;
        else if (rem == 8'd0) return 3'b111;
        else                 return 3'b010;
    endfunction

    // Wrapping bursts only step the low word-index bits; upper bits hold.
    function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
        logic [31:0] n;
        n = a;
        case (bte)
            2'b00:   n = a + 32'd4;
            2'b01:   n[3:2] = a[3:2] + 2'd1;
            2'b10:   n[4:2] = a[4:2] + 3'd1;
            default: n[5:2] = a[5:2] + 4'd1;
        endcase
        return n;
    endfunction

    // On writes the strobe is withheld while no data word is offered, which
    // inserts master wait states without dropping cyc.
    assign wb_stb_o     = stb_q & (~wb_we_o | wdat_valid_i);
    assign wb_dat_o     = wdat_i;
    assign wb_sel_o     = wb_cyc_o ? (wb_we_o ? wdat_sel_i : 4'hF) : 4'h0;
    assign wdat_ready_o = wb_ack_i & wb_stb_o & wb_we_o;
    assign cmd_ready_o  = (state == S_IDLE);
    assign dbg_state_o  = state;

    assign term_ack = wb_stb_o & wb_ack_i;
    assign term_err = wb_stb_o & wb_err_i;
    assign term_rty = wb_stb_o & wb_rty_i;
    assign rd_beat  = (state == S_BUS) & term_ack & ~term_err & ~term_rty & ~wb_we_o;

    // Command completion decision, with err > rty > ack priority.
    always_comb begin
        fin        = 1'b0;
        fin_status = 2'b00;
        if (state == S_BUS) begin
            if (term_err) begin
                fin        = 1'b1;
                fin_status = 2'b01;
            end else if (term_rty) begin
                if (rty_cnt == RTY_MAX) begin
                    fin        = 1'b1;
                    fin_status = 2'b10;
                end
            end else if (term_ack) begin
                if (rem_q == 8'd0) begin
                    fin        = 1'b1;
                    fin_status = 2'b00;
                end
            end else if (TO_EN && (to_cnt == TO_LAST)) begin
                fin        = 1'b1;
                fin_status = 2'b11;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state        <= S_IDLE;
            wb_cyc_o     <= 1'b0;
            stb_q        <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= 32'd0;
            wb_cti_o     <= 3'b000;
            wb_bte_o     <= 2'b00;
            len_zero_q   <= 1'b0;
            rem_q        <= 8'd0;
            rty_cnt      <= 8'd0;
            gap_cnt      <= 16'd0;
            to_cnt       <= 32'd0;
            rdat_o       <= 32'd0;
            rdat_valid_o <= 1'b0;
            done_o       <= 1'b0;
            status_o     <= 2'b00;
        end else begin
            done_o       <= 1'b0;
            rdat_valid_o <= rd_beat;
            if (rd_beat) rdat_o <= wb_dat_i;

            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        wb_we_o    <= cmd_we_i;
                        wb_adr_o   <= {cmd_adr_i[31:2], 2'b00};
                        wb_bte_o   <= cmd_bte_i;
                        rem_q      <= cmd_len_i;
                        len_zero_q <= (cmd_len_i == 8'd0);
                        wb_cti_o   <= cti_for(cmd_len_i == 8'd0, cmd_len_i);
                        rty_cnt    <= 8'd0;
                        to_cnt     <= 32'd0;
                        status_o   <= 2'b00;
                        wb_cyc_o   <= 1'b1;
                        stb_q      <= 1'b1;
                        state      <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (fin) begin
                        wb_cyc_o <= 1'b0;
                        stb_q    <= 1'b0;
                        done_o   <= 1'b1;
                        status_o <= fin_status;
                        state    <= S_IDLE;
                    end else if (term_rty) begin
                        // Address and remaining count are untouched so the
                        // burst resumes at the retried beat.
                        rty_cnt  <= rty_cnt + 8'd1;
                        gap_cnt  <= GAP_LAST;
                        to_cnt   <= 32'd0;
                        wb_cyc_o <= 1'b0;
                        stb_q    <= 1'b0;
                        state    <= S_RWAIT;
                    end else if (term_ack) begin
                        to_cnt   <= 32'd0;
                        rem_q    <= rem_q - 8'd1;
                        wb_adr_o <= next_adr(wb_adr_o, wb_bte_o);
                        wb_cti_o <= cti_for(len_zero_q, rem_q - 8'd1);
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end

                S_RWAIT: begin
                    if (gap_cnt == 16'd0) begin
                        wb_cti_o <= cti_for(len_zero_q, rem_q);
                        wb_cyc_o <= 1'b1;
                        stb_q    <= 1'b1;
                        state    <= S_BUS;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master
// Self-checking bench for wb_burst_master. A table of commands with their
// expected status and beat count is run first, then randomized commands,
// then an asynchronous reset in the middle of a burst. Bus addresses, cti,
// read data and write data are predicted by a small arithmetic model of the
// burst rules; the slave side is played by the bench itself.
module tb_wb_burst_master;

    localparam int RETRY_GAP = 4;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 16;
    localparam int BUDGET    = 1500;

    localparam int M_NORM = 0;   // acks with random wait states
    localparam int M_ERR  = 1;   // err on beat k
    localparam int M_RTY1 = 2;   // one rty on beat k, then acks
    localparam int M_RTYP = 3;   // rty on beat k forever
    localparam int M_SIL  = 4;   // slave never answers

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  len;
        logic [1:0]  bte;
        int          mode;
        int          k;
        int          hold;
        int          wait_pct;
        logic [1:0]  exp_status;
        int          exp_acked;
    } vec_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [7:0]  cmd_len_i = '0;
    logic [1:0]  cmd_bte_i = '0;
    logic [31:0] wdat_i = '0;
    logic [3:0]  wdat_sel_i = '0;
    logic        wdat_valid_i = 1'b0;
    logic        wdat_ready_o;
    logic [31:0] rdat_o;
    logic        rdat_valid_o;
    logic        done_o;
    logic [1:0]  status_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic [1:0]  dbg_state_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[10];

    wb_burst_master #(
        .RETRY_GAP(RETRY_GAP),
        .MAX_RETRY(MAX_RETRY),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n_i  (wb_rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_bte_i   (cmd_bte_i),
        .wdat_i      (wdat_i),
        .wdat_sel_i  (wdat_sel_i),
        .wdat_valid_i(wdat_valid_i),
        .wdat_ready_o(wdat_ready_o),
        .rdat_o      (rdat_o),
        .rdat_valid_o(rdat_valid_o),
        .done_o      (done_o),
        .status_o    (status_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cti_o    (wb_cti_o),
        .wb_bte_o    (wb_bte_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_rty_i    (wb_rty_i),
        .dbg_state_o (dbg_state_o)
    );

    // Clock / reset
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: address of beat i of a burst. Wrapping bursts stay in
    // an aligned block of 16/32/64 bytes.
    function automatic logic [31:0] model_adr(input logic [31:0] base, input logic [1:0] bte, input int i);
        logic [31:0] b;
        logic [31:0] span;
        b = base & 32'hFFFF_FFFC;
        if (bte == 2'b00) return b + 32'(4 * i);
        span = 32'd8 << bte;
        return (b & ~(span - 32'd1)) | ((b + 32'(4 * i)) & (span - 32'd1));
    endfunction

    function automatic logic [2:0] model_cti(input logic [7:0] len, input int i);
        if (len == 8'd0)    return 3'b000;
        if (i == int'(len)) return 3'b111;
        return 3'b010;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Driver + slave: issues one command at the current negedge and plays the
    // slave until done_o, checking each terminated beat against the model.
    task automatic run_cmd(input vec_t v);
        logic [31:0] wtab [256];
        logic [3:0]  sel;
        logic [31:0] a;
        int acked, term_cyc, done_cyc, hold_left, stb_cycles;
        int rd_pulses, wr_pulses, gap, nwait;
        bit in_gap, retried, done_seen, hold_chk, do_ack, do_err, do_rty;

        sel = v.we ? 4'($urandom_range(1, 15)) : 4'hF;
        for (int i = 0; i < 256; i++) wtab[i] = $urandom;
        exp_q.delete();
        acked = 0; term_cyc = 0; done_cyc = 0; hold_left = 0; stb_cycles = 0;
        rd_pulses = 0; wr_pulses = 0; gap = 0; nwait = 0;
        in_gap = 0; retried = 0; done_seen = 0;

        check("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_len_i   = v.len;
        cmd_bte_i   = v.bte;
        @(posedge wb_clk_i);

        for (int cyc_n = 1; cyc_n <= BUDGET && !done_seen; cyc_n++) begin
            @(negedge wb_clk_i);
            cmd_valid_i = 1'b0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            hold_chk = 0;
            if (cyc_n == 1) begin
                check("cyc_after_accept", 32'(wb_cyc_o), 32'd1);
                check("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
            end
            if (rdat_valid_o) begin
                rd_pulses++;
                if (exp_q.size() > 0) check("rdat", rdat_o, exp_q.pop_front());
                else check("rdat_unexpected", 32'(rdat_valid_o), 32'd0);
            end
            if (done_o) begin
                done_seen = 1;
                done_cyc  = cyc_n;
            end else begin
                if (in_gap) begin
                    if (!wb_cyc_o) gap++;
                    else begin
                        check("retry_gap", 32'(gap), 32'(RETRY_GAP));
                        in_gap = 0;
                    end
                end
                if (v.we) begin
                    if (hold_left > 0) begin
                        wdat_valid_i = 1'b0;
                        hold_left--;
                        hold_chk = 1;
                    end else begin
                        wdat_valid_i = (nwait >= 8) || ($urandom_range(0, 99) >= v.wait_pct);
                    end
                    wdat_i     = wtab[(acked > 255) ? 255 : acked];
                    wdat_sel_i = sel;
                end
                #1;
                if (hold_chk) begin
                    check("hold_cyc", 32'(wb_cyc_o), 32'd1);
                    check("hold_stb", 32'(wb_stb_o), 32'd0);
                end
                do_ack = 0; do_err = 0; do_rty = 0;
                if (wb_stb_o) begin
                    stb_cycles++;
                    case (v.mode)
                        M_ERR:  do_err = (acked == v.k);
                        M_RTY1: if (acked == v.k && !retried) begin do_rty = 1; retried = 1; end
                        M_RTYP: do_rty = (acked == v.k);
                        default: ;
                    endcase
                    if (!do_err && !do_rty && v.mode != M_SIL)
                        do_ack = (nwait >= 8) || ($urandom_range(0, 99) >= v.wait_pct);
                end
                if (do_ack || do_err || do_rty) begin
                    a = model_adr(v.adr, v.bte, acked);
                    check("adr", wb_adr_o, a);
                    check("cti", 32'(wb_cti_o), 32'(model_cti(v.len, acked)));
                    check("we", 32'(wb_we_o), 32'(v.we));
                    check("bte", 32'(wb_bte_o), 32'(v.bte));
                    check("sel", 32'(wb_sel_o), 32'(sel));
                    if (v.we) check("wdat", wb_dat_o, wtab[acked]);
                    term_cyc = cyc_n;
                    nwait    = 0;
                    wb_ack_i = do_ack; wb_err_i = do_err; wb_rty_i = do_rty;
                    if (do_ack && !v.we) begin
                        wb_dat_i = mem_word(a);
                        exp_q.push_back(mem_word(a));
                    end
                    #1;
                    check("wdat_ready", 32'(wdat_ready_o), 32'(do_ack && v.we));
                    if (wdat_ready_o) wr_pulses++;
                    if (do_ack) begin
                        acked++;
                        if (acked == 1) hold_left = v.hold;
                    end
                    if (do_rty) begin
                        in_gap = 1;
                        gap    = 0;
                    end
                end else if (wb_cyc_o) begin
                    nwait++;
                end
            end
        end

        wdat_valid_i = 1'b0;
        check("done_seen", 32'(done_seen), 32'd1);
        check("status", 32'(status_o), 32'(v.exp_status));
        check("beats", 32'(acked), 32'(v.exp_acked));
        check("rdat_pulses", 32'(rd_pulses), v.we ? 32'd0 : 32'(v.exp_acked));
        check("wdat_ready_pulses", 32'(wr_pulses), v.we ? 32'(v.exp_acked) : 32'd0);
        check("cyc_at_done", 32'(wb_cyc_o), 32'd0);
        check("ready_at_done", 32'(cmd_ready_o), 32'd1);
        if (v.mode == M_SIL) check("timeout_stb_cycles", 32'(stb_cycles), 32'(TIMEOUT));
        else check("done_lag", 32'(done_cyc - term_cyc), 32'd1);
    endtask

    initial begin
        vec_t rv;

        // we, adr, len, bte, mode, k, hold, wait%, status, beats
        vecs[0] = '{1'b0, 32'h0000_0100, 8'd3,   2'b00, M_NORM, 0, 0, 0,  2'b00, 4};
        vecs[1] = '{1'b1, 32'h0000_0108, 8'd3,   2'b01, M_NORM, 0, 2, 0,  2'b00, 4};
        vecs[2] = '{1'b0, 32'h0000_0200, 8'd0,   2'b00, M_NORM, 0, 0, 0,  2'b00, 1};
        vecs[3] = '{1'b0, 32'h0000_0100, 8'd3,   2'b00, M_RTY1, 1, 0, 0,  2'b00, 4};
        vecs[4] = '{1'b0, 32'h0000_0100, 8'd3,   2'b00, M_RTYP, 1, 0, 0,  2'b10, 1};
        vecs[5] = '{1'b0, 32'h0000_0300, 8'd7,   2'b10, M_ERR,  0, 0, 0,  2'b01, 0};
        vecs[6] = '{1'b1, 32'h0000_0400, 8'd1,   2'b00, M_SIL,  0, 0, 0,  2'b11, 0};
        vecs[7] = '{1'b0, 32'h0000_013C, 8'd15,  2'b11, M_NORM, 0, 0, 30, 2'b00, 16};
        vecs[8] = '{1'b1, 32'h0000_01F8, 8'd7,   2'b10, M_RTY1, 7, 0, 20, 2'b00, 8};
        vecs[9] = '{1'b0, 32'h0000_1003, 8'd255, 2'b00, M_NORM, 0, 0, 10, 2'b00, 256};

        // Reset state
        wb_rst_n_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_cti", 32'(wb_cti_o), 32'd0);
        check("rst_bte", 32'(wb_bte_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_rdat_valid", 32'(rdat_valid_o), 32'd0);
        check("rst_rdat", rdat_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_status", 32'(status_o), 32'd0);
        check("rst_wdat_ready", 32'(wdat_ready_o), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        // Table-driven commands, issued back to back
        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            rv.we         = 1'($urandom_range(0, 1));
            rv.adr        = $urandom & 32'h000F_FFFF;
            rv.len        = 8'($urandom_range(0, 20));
            rv.bte        = 2'($urandom_range(0, 3));
            rv.mode       = ($urandom_range(0, 3) == 0) ? M_RTY1 : M_NORM;
            rv.k          = $urandom_range(0, int'(rv.len));
            rv.hold       = 0;
            rv.wait_pct   = $urandom_range(0, 40);
            rv.exp_status = 2'b00;
            rv.exp_acked  = int'(rv.len) + 1;
            run_cmd(rv);
        end

        // Asynchronous reset in the middle of a read burst
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h0000_0500;
        cmd_len_i   = 8'd7;
        cmd_bte_i   = 2'b00;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        wb_ack_i    = 1'b1;
        wb_dat_i    = 32'hCAFE_0001;
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        check("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
        check("pre_rst_rdat_valid", 32'(rdat_valid_o), 32'd1);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        check("midrst_cyc", 32'(wb_cyc_o), 32'd0);
        check("midrst_stb", 32'(wb_stb_o), 32'd0);
        check("midrst_rdat_valid", 32'(rdat_valid_o), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        check("postrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("postrst_cyc", 32'(wb_cyc_o), 32'd0);
        check("postrst_status", 32'(status_o), 32'd0);
        check("postrst_done", 32'(done_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
